// File: rtl/pool2d_stream.sv
// Streaming 2-D max/average pooling over a raster-order pixel stream, valid/ready on both sides.
// Line buffers hold the previous WINDOW-1 rows; a column-shift register window completes each pooling window.
module pool2d_stream #(
  parameter int CHANNELS     = 6,
  parameter int DATA_WIDTH   = 16,
  parameter int INPUT_WIDTH  = 28,
  parameter int INPUT_HEIGHT = 28,
  parameter int WINDOW       = 2,
  parameter int STRIDE       = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mode_max,
  input  logic [DATA_WIDTH*CHANNELS-1:0] in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [DATA_WIDTH*CHANNELS-1:0] out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         frame_done
);

  localparam int PW       = DATA_WIDTH * CHANNELS;
  localparam int SHIFT    = (WINDOW == 4) ? 4 : 2;
  localparam int SW       = DATA_WIDTH + SHIFT;
  localparam int OUT_W    = (INPUT_WIDTH - WINDOW) / STRIDE + 1;
  localparam int OUT_H    = (INPUT_HEIGHT - WINDOW) / STRIDE + 1;
  localparam int LAST_COL = (OUT_W - 1) * STRIDE + WINDOW - 1;
  localparam int LAST_ROW = (OUT_H - 1) * STRIDE + WINDOW - 1;
  localparam int CW       = $clog2(INPUT_WIDTH);
  localparam int RW       = $clog2(INPUT_HEIGHT);

  // Handshake: a beat transfers on a side in any cycle where valid && ready. Valid never waits on ready;
  // out_valid/out_data hold until taken, and in_ready = !out_valid || out_ready.
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          mode_q;
  logic          out_last;
  logic [PW-1:0] line_buf [WINDOW-1][INPUT_WIDTH];
  logic [PW-1:0] win_q    [WINDOW][WINDOW-1];
  logic [PW-1:0] col_vec  [WINDOW];
  logic [PW-1:0] full_win [WINDOW][WINDOW];
  logic [PW-1:0] pool_res;
  logic          accept, first_beat, eff_mode, row_hit, col_hit, emit;

  assign in_ready   = !out_valid || out_ready;
  assign accept     = in_valid && in_ready;
  assign first_beat = (row == '0) && (col == '0);
  assign eff_mode   = first_beat ? mode_max : mode_q;
  assign row_hit    = (int'(row) >= WINDOW - 1) && (((int'(row) - (WINDOW - 1)) % STRIDE) == 0);
  assign col_hit    = (int'(col) >= WINDOW - 1) && (((int'(col) - (WINDOW - 1)) % STRIDE) == 0);
  assign emit       = accept && row_hit && col_hit;
  assign frame_done = out_valid && out_ready && out_last;

  // col_vec[k] is the current column of row (row - k); index 0 is the incoming beat.
  always_comb begin
    col_vec[0] = in_data;
    for (int k = 1; k < WINDOW; k++) col_vec[k] = line_buf[k-1][col];
    for (int k = 0; k < WINDOW; k++) begin
      for (int j = 0; j < WINDOW - 1; j++) full_win[k][j] = win_q[k][j];
      full_win[k][WINDOW-1] = col_vec[k];
    end
  end

  always_comb begin
    logic signed [DATA_WIDTH-1:0] s;
    logic signed [DATA_WIDTH-1:0] mx;
    logic signed [SW-1:0]         sum;
    pool_res = '0;
    s        = '0;
    mx       = '0;
    sum      = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      mx  = $signed(full_win[0][0][c*DATA_WIDTH +: DATA_WIDTH]);
      sum = '0;
      for (int k = 0; k < WINDOW; k++) begin
        for (int j = 0; j < WINDOW; j++) begin
          s   = $signed(full_win[k][j][c*DATA_WIDTH +: DATA_WIDTH]);
          sum = sum + SW'(s);
          if (s > mx) mx = s;
        end
      end
      // Arithmetic shift floors toward -inf; the quotient of WINDOW^2 samples always fits DATA_WIDTH.
      pool_res[c*DATA_WIDTH +: DATA_WIDTH] = eff_mode ? mx : DATA_WIDTH'(sum >>> SHIFT);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      line_buf[0][col] <= in_data;
      for (int k = 1; k < WINDOW - 1; k++) line_buf[k][col] <= line_buf[k-1][col];
      for (int k = 0; k < WINDOW; k++) begin
        for (int j = 0; j < WINDOW - 2; j++) win_q[k][j] <= win_q[k][j+1];
        win_q[k][WINDOW-2] <= col_vec[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      mode_q    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept) begin
        if (first_beat) mode_q <= mode_max;
        if (col == CW'(INPUT_WIDTH - 1)) begin
          col <= '0;
          row <= (row == RW'(INPUT_HEIGHT - 1)) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (emit) begin
          out_valid <= 1'b1;
          out_data  <= pool_res;
          out_last  <= (row == RW'(LAST_ROW)) && (col == CW'(LAST_COL));
        end
      end
    end
  end

endmodule

// File: tb/tb_pool2d_stream.sv
// Bench for pool2d_stream: several parameterisations share one stimulus driver, checked against a
// window-by-window arithmetic model of the pooled frame.
module tb_pool2d_stream;

  typedef logic [95:0] px_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, mode_max;
  logic [95:0] in_data;
  int          sel;
  logic [4:0]  rdy_k, ov_k, fd_k;
  logic [15:0] od_a, od_b, od_c;
  logic [95:0] od_d;
  logic [31:0] od_e;
  logic        cur_in_ready, cur_out_valid, cur_frame_done;
  px_t         cur_out_data;

  px_t  frm[$], in_q[$], exp_q[$], obs_q[$], st_data_q[$];
  logic md_q[$], exp_fd_q[$], obs_fd_q[$], st_rdy_q[$], st_ov_q[$];
  int   acc_cyc_q[$], obs_cyc_q[$], exp_beat_q[$];
  int   beat_base;
  int   n_vec, n_err;

  always #5 clk = ~clk;

  pool2d_stream #(.CHANNELS(1), .DATA_WIDTH(16), .INPUT_WIDTH(4), .INPUT_HEIGHT(4), .WINDOW(2), .STRIDE(2)) dut_a (
    .clk(clk), .rst(rst), .mode_max(mode_max), .in_data(in_data[15:0]), .in_valid(in_valid && sel == 0),
    .in_ready(rdy_k[0]), .out_data(od_a), .out_valid(ov_k[0]), .out_ready(out_ready), .frame_done(fd_k[0]));
  pool2d_stream #(.CHANNELS(1), .DATA_WIDTH(16), .INPUT_WIDTH(3), .INPUT_HEIGHT(3), .WINDOW(2), .STRIDE(1)) dut_b (
    .clk(clk), .rst(rst), .mode_max(mode_max), .in_data(in_data[15:0]), .in_valid(in_valid && sel == 1),
    .in_ready(rdy_k[1]), .out_data(od_b), .out_valid(ov_k[1]), .out_ready(out_ready), .frame_done(fd_k[1]));
  pool2d_stream #(.CHANNELS(1), .DATA_WIDTH(16), .INPUT_WIDTH(5), .INPUT_HEIGHT(5), .WINDOW(2), .STRIDE(2)) dut_c (
    .clk(clk), .rst(rst), .mode_max(mode_max), .in_data(in_data[15:0]), .in_valid(in_valid && sel == 2),
    .in_ready(rdy_k[2]), .out_data(od_c), .out_valid(ov_k[2]), .out_ready(out_ready), .frame_done(fd_k[2]));
  pool2d_stream #(.CHANNELS(6), .DATA_WIDTH(16), .INPUT_WIDTH(28), .INPUT_HEIGHT(28), .WINDOW(2), .STRIDE(2)) dut_d (
    .clk(clk), .rst(rst), .mode_max(mode_max), .in_data(in_data), .in_valid(in_valid && sel == 3),
    .in_ready(rdy_k[3]), .out_data(od_d), .out_valid(ov_k[3]), .out_ready(out_ready), .frame_done(fd_k[3]));
  pool2d_stream #(.CHANNELS(2), .DATA_WIDTH(16), .INPUT_WIDTH(8), .INPUT_HEIGHT(7), .WINDOW(4), .STRIDE(3)) dut_e (
    .clk(clk), .rst(rst), .mode_max(mode_max), .in_data(in_data[31:0]), .in_valid(in_valid && sel == 4),
    .in_ready(rdy_k[4]), .out_data(od_e), .out_valid(ov_k[4]), .out_ready(out_ready), .frame_done(fd_k[4]));

  always_comb begin
    cur_in_ready   = rdy_k[sel[2:0]];
    cur_out_valid  = ov_k[sel[2:0]];
    cur_frame_done = fd_k[sel[2:0]];
    case (sel)
      0:       cur_out_data = {80'b0, od_a};
      1:       cur_out_data = {80'b0, od_b};
      2:       cur_out_data = {80'b0, od_c};
      3:       cur_out_data = od_d;
      default: cur_out_data = {64'b0, od_e};
    endcase
  end

  task automatic clear_q();
    frm.delete(); in_q.delete(); md_q.delete(); exp_q.delete(); exp_fd_q.delete(); exp_beat_q.delete();
    beat_base = 0;
  endtask

  task automatic gen_rand(input int n, input int ch);
    px_t p;
    frm.delete();
    for (int i = 0; i < n; i++) begin
      p = '0;
      for (int c = 0; c < ch; c++) p[c*16 +: 16] = 16'($urandom);
      frm.push_back(p);
    end
  endtask

  // Reference: pools each output window directly from the frame; average is floor(sum / WINDOW^2).
  task automatic queue_frame(input int w, input int h, input int win, input int str, input int ch,
                             input logic mode, input int toggle_at);
    int ow, oh, sum, mx, v, q;
    px_t p, r;
    ow = (w - win) / str + 1;
    oh = (h - win) / str + 1;
    for (int i = 0; i < w * h; i++) begin
      in_q.push_back(frm[i]);
      md_q.push_back((toggle_at >= 0 && i >= toggle_at) ? ~mode : mode);
    end
    for (int oy = 0; oy < oh; oy++) begin
      for (int ox = 0; ox < ow; ox++) begin
        r = '0;
        for (int c = 0; c < ch; c++) begin
          sum = 0;
          mx  = -100000;
          for (int dy = 0; dy < win; dy++) begin
            for (int dx = 0; dx < win; dx++) begin
              p   = frm[(oy * str + dy) * w + ox * str + dx];
              v   = int'($signed(p[c*16 +: 16]));
              sum = sum + v;
              if (v > mx) mx = v;
            end
          end
          if (mode) q = mx;
          else begin
            q = sum / (win * win);
            if (sum < 0 && q * win * win != sum) q = q - 1;
          end
          r[c*16 +: 16] = q[15:0];
        end
        exp_q.push_back(r);
        exp_fd_q.push_back(oy == oh - 1 && ox == ow - 1);
        exp_beat_q.push_back(beat_base + (oy * str + win - 1) * w + ox * str + win - 1);
      end
    end
    beat_base = beat_base + w * h;
  endtask

  task automatic run_stream(input int rdy_pct, input int stall);
    int   guard, cyc, stall_left;
    logic stalled;
    guard = 0; cyc = 0; stall_left = stall;
    obs_q.delete(); obs_fd_q.delete(); obs_cyc_q.delete(); acc_cyc_q.delete();
    st_data_q.delete(); st_rdy_q.delete(); st_ov_q.delete();
    while ((in_q.size() > 0 || obs_q.size() < exp_q.size()) && guard < 4000) begin
      @(negedge clk);
      in_valid = (in_q.size() > 0);
      if (in_valid) begin
        in_data  = in_q[0];
        mode_max = md_q[0];
      end else in_data = '0;
      stalled = cur_out_valid && stall_left > 0;
      if (stalled) begin
        out_ready  = 1'b0;
        stall_left = stall_left - 1;
      end else out_ready = ($urandom_range(99) < rdy_pct);
      #1;
      if (stalled) begin
        st_data_q.push_back(cur_out_data); st_rdy_q.push_back(cur_in_ready); st_ov_q.push_back(cur_out_valid);
      end
      if (cur_out_valid && out_ready) begin
        obs_q.push_back(cur_out_data); obs_fd_q.push_back(cur_frame_done); obs_cyc_q.push_back(cyc);
      end
      if (in_valid && cur_in_ready) begin
        void'(in_q.pop_front()); void'(md_q.pop_front()); acc_cyc_q.push_back(cyc);
      end
      cyc++;
      guard++;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      sel = k;
      #1;
      n_vec++; if (cur_out_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid dut%0d: got %b want 0", k, cur_out_valid); end
      n_vec++; if (cur_out_data !== '0) begin n_err++; $display("FAIL reset out_data dut%0d: got %h want 0", k, cur_out_data); end
      n_vec++; if (cur_frame_done !== 1'b0) begin n_err++; $display("FAIL reset frame_done dut%0d: got %b want 0", k, cur_frame_done); end
      n_vec++; if (cur_in_ready !== 1'b1) begin n_err++; $display("FAIL reset in_ready dut%0d: got %b want 1", k, cur_in_ready); end
    end
    out_ready = 1'b1;
  endtask

  task automatic test_avg_basic();
    logic [15:0] lit [4];
    lit = '{16'd2, 16'd4, 16'd10, 16'd12};
    sel = 0; clear_q();
    for (int i = 0; i < 16; i++) frm.push_back(px_t'(i));
    queue_frame(4, 4, 2, 2, 1, 1'b0, -1);
    run_stream(100, 0);
    n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL avg_basic count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++; if (obs_q[i][15:0] !== lit[i]) begin n_err++; $display("FAIL avg_basic data[%0d]: got %0d want %0d", i, obs_q[i][15:0], lit[i]); end
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL avg_basic model[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
      n_vec++; if (obs_fd_q[i] !== exp_fd_q[i]) begin n_err++; $display("FAIL avg_basic frame_done[%0d]: got %b want %b", i, obs_fd_q[i], exp_fd_q[i]); end
      if (exp_beat_q[i] < acc_cyc_q.size()) begin
        n_vec++; if (obs_cyc_q[i] != acc_cyc_q[exp_beat_q[i]] + 1) begin
          n_err++; $display("FAIL avg_basic latency[%0d]: got cycle %0d want %0d", i, obs_cyc_q[i], acc_cyc_q[exp_beat_q[i]] + 1);
        end
      end
    end
  endtask

  task automatic test_max_toggle();
    sel = 0; clear_q();
    for (int i = 0; i < 16; i++) frm.push_back(px_t'(i));
    queue_frame(4, 4, 2, 2, 1, 1'b1, 6);
    gen_rand(16, 1);
    queue_frame(4, 4, 2, 2, 1, 1'b0, 3);
    run_stream(100, 0);
    n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL max_toggle count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL max_toggle data[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
      n_vec++; if (obs_fd_q[i] !== exp_fd_q[i]) begin n_err++; $display("FAIL max_toggle frame_done[%0d]: got %b want %b", i, obs_fd_q[i], exp_fd_q[i]); end
    end
    n_vec++; if (obs_q.size() > 3 && obs_q[3][15:0] !== 16'd15) begin n_err++; $display("FAIL max_toggle last: got %0d want 15", obs_q[3][15:0]); end
  endtask

  task automatic test_neg_avg();
    sel = 0; clear_q();
    gen_rand(16, 1);
    frm[0] = px_t'(16'hffff); frm[1] = px_t'(16'hfffe); frm[4] = px_t'(16'hfffd); frm[5] = px_t'(16'hfffc);
    frm[10] = px_t'(16'h8000); frm[11] = px_t'(16'h8000); frm[14] = px_t'(16'h8000); frm[15] = px_t'(16'h8000);
    queue_frame(4, 4, 2, 2, 1, 1'b0, -1);
    run_stream(100, 0);
    n_vec++; if (obs_q.size() != 4) begin n_err++; $display("FAIL neg_avg count: got %0d want 4", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL neg_avg data[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    if (obs_q.size() == 4) begin
      n_vec++; if (obs_q[0][15:0] !== 16'hfffd) begin n_err++; $display("FAIL neg_avg floor: got %h want fffd", obs_q[0][15:0]); end
      n_vec++; if (obs_q[3][15:0] !== 16'h8000) begin n_err++; $display("FAIL neg_avg min: got %h want 8000", obs_q[3][15:0]); end
    end
  endtask

  task automatic test_stride_trailing();
    logic [15:0] lit [4];
    lit = '{16'd4, 16'd5, 16'd7, 16'd8};
    sel = 1; clear_q();
    for (int i = 0; i < 9; i++) frm.push_back(px_t'(i));
    queue_frame(3, 3, 2, 1, 1, 1'b1, -1);
    run_stream(100, 0);
    n_vec++; if (obs_q.size() != 4) begin n_err++; $display("FAIL stride1 count: got %0d want 4", obs_q.size()); end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      n_vec++; if (obs_q[i][15:0] !== lit[i]) begin n_err++; $display("FAIL stride1 data[%0d]: got %0d want %0d", i, obs_q[i][15:0], lit[i]); end
      n_vec++; if (obs_fd_q[i] !== exp_fd_q[i]) begin n_err++; $display("FAIL stride1 frame_done[%0d]: got %b want %b", i, obs_fd_q[i], exp_fd_q[i]); end
    end
    sel = 2; clear_q();
    gen_rand(25, 1);
    queue_frame(5, 5, 2, 2, 1, 1'b0, -1);
    gen_rand(25, 1);
    queue_frame(5, 5, 2, 2, 1, 1'b1, -1);
    run_stream(80, 0);
    n_vec++; if (obs_q.size() != 8) begin n_err++; $display("FAIL trailing count: got %0d want 8", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL trailing data[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
      n_vec++; if (obs_fd_q[i] !== exp_fd_q[i]) begin n_err++; $display("FAIL trailing frame_done[%0d]: got %b want %b", i, obs_fd_q[i], exp_fd_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    sel = 0; clear_q();
    for (int i = 0; i < 16; i++) frm.push_back(px_t'(i));
    queue_frame(4, 4, 2, 2, 1, 1'b0, -1);
    run_stream(100, 5);
    n_vec++; if (st_data_q.size() != 5) begin n_err++; $display("FAIL stall cycles: got %0d want 5", st_data_q.size()); end
    for (int i = 0; i < st_data_q.size(); i++) begin
      n_vec++; if (st_data_q[i] !== exp_q[0]) begin n_err++; $display("FAIL stall hold[%0d]: got %h want %h", i, st_data_q[i], exp_q[0]); end
      n_vec++; if (st_rdy_q[i] !== 1'b0) begin n_err++; $display("FAIL stall in_ready[%0d]: got %b want 0", i, st_rdy_q[i]); end
      n_vec++; if (st_ov_q[i] !== 1'b1) begin n_err++; $display("FAIL stall out_valid[%0d]: got %b want 1", i, st_ov_q[i]); end
    end
    n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL stall count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL stall data[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 2; k++) begin
      sel = (k == 0) ? 0 : 4;
      clear_q();
      for (int f = 0; f < 3; f++) begin
        if (k == 0) begin gen_rand(16, 1); queue_frame(4, 4, 2, 2, 1, 1'($urandom_range(1)), -1); end
        else begin gen_rand(56, 2); queue_frame(8, 7, 4, 3, 2, 1'($urandom_range(1)), 10); end
      end
      run_stream(50, 0);
      n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL b2b%0d count: got %0d want %0d", k, obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL b2b%0d data[%0d]: got %h want %h", k, i, obs_q[i], exp_q[i]); end
        n_vec++; if (obs_fd_q[i] !== exp_fd_q[i]) begin n_err++; $display("FAIL b2b%0d frame_done[%0d]: got %b want %b", k, i, obs_fd_q[i], exp_fd_q[i]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    px_t p;
    sel = 3; clear_q();
    gen_rand(3 * 28 + 10, 6);
    for (int i = 0; i < frm.size(); i++) begin in_q.push_back(frm[i]); md_q.push_back(1'b1); end
    run_stream(70, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++; if (cur_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_mid out_valid: got %b want 0", cur_out_valid); end
    n_vec++; if (cur_out_data !== '0) begin n_err++; $display("FAIL reset_mid out_data: got %h want 0", cur_out_data); end
    n_vec++; if (cur_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_mid in_ready: got %b want 1", cur_in_ready); end
    clear_q();
    for (int m = 0; m < 2; m++) begin
      frm.delete();
      for (int i = 0; i < 784; i++) begin
        p = '0;
        for (int c = 0; c < 6; c++) p[c*16 +: 16] = (c % 2 == 0) ? 16'(i + c) : 16'(-(i + c));
        frm.push_back(p);
      end
      queue_frame(28, 28, 2, 2, 6, 1'(m), -1);
    end
    run_stream(60, 0);
    n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL reset_mid count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL reset_mid data[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
      n_vec++; if (obs_fd_q[i] !== exp_fd_q[i]) begin n_err++; $display("FAIL reset_mid frame_done[%0d]: got %b want %b", i, obs_fd_q[i], exp_fd_q[i]); end
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0; beat_base = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mode_max = 1'b0; in_data = '0; sel = 0;
    test_reset();
    test_avg_basic();
    test_max_toggle();
    test_neg_avg();
    test_stride_trailing();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
